// File: rtl/cmutex_split6_sync.sv
// cmutex_split6_sync
//   Clocked six-way token splitter. A single upstream drive/data token is
//   steered to one of six downstream channels (i_sel). The channel is held
//   until its free pulse returns, then upstream is released with o_free.
//   Programmable DRIVE_DELAY / FREE_DELAY cycle counts stand in for the
//   delay elements of the asynchronous version.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   i_drive       upstream token-valid pulse
//   i_sel, i_data destination channel (0..5) and payload, valid with i_drive
//   o_free        upstream release pulse
//   o_drive[5:0]  per-channel drive pulse (one-hot or zero)
//   o_data        captured payload, shared by all channels
//   i_free[5:0]   per-channel free pulses from downstream
//   o_busy        high whenever not IDLE
//   o_sel_err     pulse: token arrived with i_sel > 5
//   o_proto_err   pulse: protocol violation seen in the previous cycle
module cmutex_split6_sync #(
    parameter int DATA_WIDTH  = 32,
    parameter int DRIVE_DELAY = 4,
    parameter int FREE_DELAY  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_drive,
    input  logic [2:0]            i_sel,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_free,
    output logic [5:0]            o_drive,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic [5:0]            i_free,
    output logic                  o_busy,
    output logic                  o_sel_err,
    output logic                  o_proto_err
);

    typedef enum logic [1:0] {IDLE, DRV_DLY, WAIT_FREE, FREE_DLY} state_t;

    localparam logic [3:0] DRV_LOAD  = 4'(DRIVE_DELAY - 1);
    localparam logic [3:0] FREE_LOAD = 4'(FREE_DELAY - 1);

    state_t                state, state_d;
    logic [3:0]            cnt, cnt_d;
    logic [2:0]            r_sel, sel_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  sel_err_q, sel_err_d;
    logic                  rej_free_q, rej_free_d;
    logic                  proto_q, proto_d;

    logic [5:0] sel_oh;
    logic [5:0] foreign;
    logic       drv_fire, free_win, free_hit, free_done;

    for (genvar k = 0; k < 6; k++) begin : g_ch
        assign sel_oh[k] = (r_sel == 3'(k));
    end

    assign drv_fire  = (state == DRV_DLY) && (cnt == 4'd0);
    // The selected channel may answer in the same cycle it is driven, so the
    // acceptance window opens on the drive cycle, not one cycle later.
    assign free_win  = drv_fire || (state == WAIT_FREE);
    assign foreign   = free_win ? (i_free & ~sel_oh) : i_free;
    assign free_hit  = free_win && |(i_free & sel_oh);
    assign free_done = (state == FREE_DLY) && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            r_sel      <= '0;
            data_q     <= '0;
            sel_err_q  <= 1'b0;
            rej_free_q <= 1'b0;
            proto_q    <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            r_sel      <= sel_d;
            data_q     <= data_d;
            sel_err_q  <= sel_err_d;
            rej_free_q <= rej_free_d;
            proto_q    <= proto_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        sel_d      = r_sel;
        data_d     = data_q;
        sel_err_d  = 1'b0;
        rej_free_d = 1'b0;
        proto_d    = (i_drive && (state != IDLE)) || (|foreign);
        case (state)
            IDLE: begin
                if (i_drive) begin
                    if (i_sel <= 3'd5) begin
                        data_d  = i_data;
                        sel_d   = i_sel;
                        cnt_d   = DRV_LOAD;
                        state_d = DRV_DLY;
                    end else begin
                        // Bad select is bounced straight back upstream.
                        sel_err_d  = 1'b1;
                        rej_free_d = 1'b1;
                    end
                end
            end
            DRV_DLY: begin
                if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else if (free_hit) begin
                    cnt_d   = FREE_LOAD;
                    state_d = FREE_DLY;
                end else begin
                    state_d = WAIT_FREE;
                end
            end
            WAIT_FREE: begin
                if (free_hit) begin
                    cnt_d   = FREE_LOAD;
                    state_d = FREE_DLY;
                end
            end
            FREE_DLY: begin
                if (cnt != 4'd0) cnt_d = cnt - 4'd1;
                else             state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_drive     = drv_fire ? sel_oh : 6'b0;
    assign o_free      = free_done | rej_free_q;
    assign o_busy      = (state != IDLE);
    assign o_data      = data_q;
    assign o_sel_err   = sel_err_q;
    assign o_proto_err = proto_q;

endmodule

// File: tb/tb_cmutex_split6_sync.sv
// tb_cmutex_split6_sync
//   Directed bench for cmutex_split6_sync with default parameters
//   (DRIVE_DELAY = FREE_DELAY = 4). Inputs change and outputs are sampled
//   1ns after each rising edge. "Cycle c" below is the cycle after the c-th
//   edge counted from the capture edge.
module tb_cmutex_split6_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_drive;
    logic [2:0]  i_sel;
    logic [31:0] i_data;
    logic [5:0]  i_free;
    logic        o_free;
    logic [5:0]  o_drive;
    logic [31:0] o_data;
    logic        o_busy;
    logic        o_sel_err;
    logic        o_proto_err;

    int checks = 0;
    int errors = 0;

    cmutex_split6_sync #(.DATA_WIDTH(32), .DRIVE_DELAY(4), .FREE_DELAY(4)) dut (
        .clk(clk), .rst(rst), .i_drive(i_drive), .i_sel(i_sel), .i_data(i_data),
        .o_free(o_free), .o_drive(o_drive), .o_data(o_data), .i_free(i_free),
        .o_busy(o_busy), .o_sel_err(o_sel_err), .o_proto_err(o_proto_err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) step;
        checks++; if (o_drive !== 6'b0) begin errors++; $display("FAIL reset_drive: got %b expected %b", o_drive, 6'b0); end
        checks++; if (o_free !== 1'b0) begin errors++; $display("FAIL reset_free: got %b expected 0", o_free); end
        checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", o_data); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        checks++; if (o_sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err: got %b expected 0", o_sel_err); end
        checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto: got %b expected 0", o_proto_err); end
        rst = 1'b0;
        step;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", o_busy); end
        checks++; if (o_drive !== 6'b0) begin errors++; $display("FAIL idle_drive: got %b expected 0", o_drive); end
    endtask

    task automatic test_single;
        logic exp_free;
        i_drive = 1'b1; i_sel = 3'd3; i_data = 32'hDEADBEEF;
        step;                                   // capture edge; now cycle 1
        i_drive = 1'b0; i_sel = 3'd0; i_data = 32'h0;
        checks++; if (o_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h expected deadbeef", o_data); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", o_busy); end
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) step;
            checks++;
            if (o_drive !== ((c == 4) ? 6'b001000 : 6'b000000)) begin
                errors++; $display("FAIL single_drive c%0d: got %b expected %b", c, o_drive, (c == 4) ? 6'b001000 : 6'b000000);
            end
        end
        step;                                   // cycle 6: two after drive
        i_free = 6'b001000;
        step;                                   // free sampled; now F+1
        i_free = 6'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) step;
            exp_free = (c == 4);
            checks++; if (o_free !== exp_free) begin errors++; $display("FAIL single_free c%0d: got %b expected %b", c, o_free, exp_free); end
            checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL single_proto c%0d: got %b expected 0", c, o_proto_err); end
        end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", o_busy); end
    endtask

    task automatic test_all_channels;
        int n_drive = 0;
        int n_free  = 0;
        logic [5:0]  exp_drv;
        logic [31:0] exp_data;
        for (int s = 0; s < 6; s++) begin
            i_drive = 1'b1; i_sel = 3'(s); i_data = 32'h10 + 32'(s);
            exp_data = 32'h10 + 32'(s);
            step;
            i_drive = 1'b0;
            for (int c = 1; c <= 8; c++) begin
                exp_drv = (c == 4) ? 6'(1 << s) : 6'b0;
                checks++; if (o_drive !== exp_drv) begin errors++; $display("FAIL all_drive s%0d c%0d: got %b expected %b", s, c, o_drive, exp_drv); end
                checks++; if (o_data !== exp_data) begin errors++; $display("FAIL all_data s%0d c%0d: got %h expected %h", s, c, o_data, exp_data); end
                checks++; if (o_free !== (c == 8)) begin errors++; $display("FAIL all_free s%0d c%0d: got %b expected %b", s, c, o_free, (c == 8)); end
                checks++; if ((o_sel_err | o_proto_err) !== 1'b0) begin errors++; $display("FAIL all_err s%0d c%0d: got %b%b expected 00", s, c, o_sel_err, o_proto_err); end
                if (|o_drive) n_drive++;
                if (o_free) n_free++;
                i_free = (c == 4) ? 6'(1 << s) : 6'b0;
                step;
            end
            i_free = 6'b0;
        end
        checks++; if (n_drive !== 6) begin errors++; $display("FAIL all_drive_count: got %0d expected 6", n_drive); end
        checks++; if (n_free !== 6) begin errors++; $display("FAIL all_free_count: got %0d expected 6", n_free); end
    endtask

    task automatic test_bad_sel;
        i_drive = 1'b1; i_sel = 3'd7; i_data = 32'h55;
        step;
        i_drive = 1'b0; i_sel = 3'd0; i_data = 32'h0;
        checks++; if (o_sel_err !== 1'b1) begin errors++; $display("FAIL badsel_err: got %b expected 1", o_sel_err); end
        checks++; if (o_free !== 1'b1) begin errors++; $display("FAIL badsel_free: got %b expected 1", o_free); end
        checks++; if (o_data !== 32'h15) begin errors++; $display("FAIL badsel_data: got %h expected 15", o_data); end
        checks++; if (o_drive !== 6'b0) begin errors++; $display("FAIL badsel_drive: got %b expected 0", o_drive); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL badsel_busy: got %b expected 0", o_busy); end
        step;
        checks++; if ((o_sel_err | o_free | o_busy) !== 1'b0) begin errors++; $display("FAIL badsel_after: got err=%b free=%b busy=%b expected 0", o_sel_err, o_free, o_busy); end
    endtask

    task automatic test_proto;
        int n_free = 0;
        i_drive = 1'b1; i_sel = 3'd1; i_data = 32'hA1;
        step;
        i_drive = 1'b0;
        repeat (3) step;                        // cycle 4
        checks++; if (o_drive !== 6'b000010) begin errors++; $display("FAIL proto_drive: got %b expected 000010", o_drive); end
        step;                                   // cycle 5: WAIT_FREE
        i_free = 6'b010000;
        step;
        i_free = 6'b0;
        checks++; if (o_proto_err !== 1'b1) begin errors++; $display("FAIL proto_foreign: got %b expected 1", o_proto_err); end
        i_drive = 1'b1; i_sel = 3'd2; i_data = 32'h22;
        step;
        i_drive = 1'b0;
        checks++; if (o_proto_err !== 1'b1) begin errors++; $display("FAIL proto_drive_busy: got %b expected 1", o_proto_err); end
        checks++; if (o_data !== 32'hA1) begin errors++; $display("FAIL proto_data: got %h expected a1", o_data); end
        checks++; if ((o_free | (|o_drive)) !== 1'b0) begin errors++; $display("FAIL proto_quiet: got free=%b drive=%b expected 0", o_free, o_drive); end
        step;
        checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL proto_clear: got %b expected 0", o_proto_err); end
        step;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL proto_waiting: got %b expected 1", o_busy); end
        i_free = 6'b000010;
        step;
        i_free = 6'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) step;
            if (o_free) n_free++;
            checks++; if (o_free !== (c == 4)) begin errors++; $display("FAIL proto_free c%0d: got %b expected %b", c, o_free, (c == 4)); end
            checks++; if ((o_proto_err | (|o_drive)) !== 1'b0) begin errors++; $display("FAIL proto_tail c%0d: got err=%b drive=%b expected 0", c, o_proto_err, o_drive); end
        end
        checks++; if (n_free !== 1) begin errors++; $display("FAIL proto_free_count: got %0d expected 1", n_free); end
    endtask

    task automatic test_reset_mid;
        i_drive = 1'b1; i_sel = 3'd2; i_data = 32'h77;
        step;
        i_drive = 1'b0;
        repeat (3) step;                        // cycle 4
        checks++; if (o_drive !== 6'b000100) begin errors++; $display("FAIL rmid_drive: got %b expected 000100", o_drive); end
        rst = 1'b1;
        step;
        rst = 1'b0;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", o_busy); end
        checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL rmid_data: got %h expected 0", o_data); end
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step;
            checks++; if ((o_free | (|o_drive)) !== 1'b0) begin errors++; $display("FAIL rmid_quiet c%0d: got free=%b drive=%b expected 0", c, o_free, o_drive); end
        end
        i_free = 6'b000100;
        step;
        i_free = 6'b0;
        checks++; if (o_proto_err !== 1'b1) begin errors++; $display("FAIL rmid_proto: got %b expected 1", o_proto_err); end
        checks++; if ((o_free | o_busy) !== 1'b0) begin errors++; $display("FAIL rmid_after: got free=%b busy=%b expected 0", o_free, o_busy); end
        step;
        checks++; if (o_proto_err !== 1'b0) begin errors++; $display("FAIL rmid_proto_clear: got %b expected 0", o_proto_err); end
    endtask

    initial begin
        rst = 1'b1; i_drive = 1'b0; i_sel = 3'd0; i_data = 32'h0; i_free = 6'b0;
        test_reset;
        test_single;
        test_all_channels;
        test_bad_sel;
        test_proto;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
